pipeline_ctrl: RTL and testbench

- Central hazard controller for the 5-stage core.
- Drives the enable and clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline flip-flops.
- Resolves four hazards: load-use stalls, taken-branch flushes, multi-cycle mul/div stalls and data-memory wait states.
- Holds a small FSM plus cycle and timeout counters; all hazard outputs act in the same cycle.

---
 rtl/core_pkg.sv | 20 ++
 rtl/md_stall_counter.sv | 67 ++++++
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and default cycle constants for the 5-stage core's control logic.
package core_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic en;
    logic clr;
  } stage_ctrl_t;

  localparam int unsigned MULT_CYCLES = 4;
  localparam int unsigned DIV_CYCLES  = 32;

  localparam stage_ctrl_t STAGE_RUN   = '{en: 1'b1, clr: 1'b0};
  localparam stage_ctrl_t STAGE_RESET = '{en: 1'b0, clr: 1'b1};

endpackage

// File: rtl/md_stall_counter.sv
// Mul/div stall sequencer: counts the remaining EX-stage cycles of a multi-cycle
// operation and pulses md_done_o on the cycle after the stall ends.
module md_stall_counter
  import core_pkg::*;
#(
  parameter int unsigned MultCycles = MULT_CYCLES,
  parameter int unsigned DivCycles  = DIV_CYCLES,
  parameter int unsigned CntWidth   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic is_div_i,
  input  logic hold_i,
  output logic stall_o,
  output logic md_done_o
);

  // The start cycle itself is a stall cycle, so the counter covers the other N-1.
  localparam logic [CntWidth-1:0] MULT_LOAD = CntWidth'(MultCycles - 1);
  localparam logic [CntWidth-1:0] DIV_LOAD  = CntWidth'(DivCycles - 1);

  md_state_e           state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      md_done_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_o <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!hold_i) begin
      unique case (state_q)
        RUN: begin
          if (start_i) begin
            cnt_d   = is_div_i ? DIV_LOAD : MULT_LOAD;
            state_d = MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (cnt_q == CntWidth'(1)) begin
            cnt_d   = '0;
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CntWidth'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign stall_o = (state_q == MD_BUSY) || start_i;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard controller: prioritises memory wait, mul/div, load-use and
// branch hazards into per-stage enable/clear controls within the same cycle.
module pipeline_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MultCycles = MULT_CYCLES,
  parameter int unsigned DivCycles  = DIV_CYCLES,
  parameter int unsigned MemTimeout = 255,
  parameter int unsigned CntWidth   = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic       id_branch_taken_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic       ex_md_start_i,
  input  logic       ex_md_is_div_i,
  input  logic       mem_req_i,
  input  logic       mem_ready_i,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       if_id_clr_o,
  output logic       id_ex_en_o,
  output logic       id_ex_clr_o,
  output logic       ex_mem_en_o,
  output logic       ex_mem_clr_o,
  output logic       mem_wb_en_o,
  output logic       mem_wb_clr_o,
  output logic       md_done_o,
  output logic       mem_err_o
);

  logic                mem_wait;
  logic                md_stall;
  logic                load_use;
  logic [CntWidth-1:0] wait_cnt;
  logic [CntWidth-1:0] wait_inc;
  logic                pc_en;
  stage_ctrl_t         if_id, id_ex, ex_mem, mem_wb;

  assign mem_wait = mem_req_i && !mem_ready_i;

  assign load_use = ex_mem_read_i && (ex_rt_i != '0) &&
                    ((id_use_rs_i && (id_rs_i == ex_rt_i)) ||
                     (id_use_rt_i && (id_rt_i == ex_rt_i)));

  md_stall_counter #(
    .MultCycles(MultCycles),
    .DivCycles (DivCycles),
    .CntWidth  (CntWidth)
  ) u_md_stall_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (ex_md_start_i),
    .is_div_i (ex_md_is_div_i),
    .hold_i   (mem_wait),
    .stall_o  (md_stall),
    .md_done_o(md_done_o)
  );

  // Only the highest-priority active hazard shapes the controls; a taken branch
  // is dropped under any stall because ID re-presents it next cycle.
  always_comb begin
    pc_en  = 1'b1;
    if_id  = STAGE_RUN;
    id_ex  = STAGE_RUN;
    ex_mem = STAGE_RUN;
    mem_wb = STAGE_RUN;
    if (!rst_ni) begin
      pc_en  = 1'b0;
      if_id  = STAGE_RESET;
      id_ex  = STAGE_RESET;
      ex_mem = STAGE_RESET;
      mem_wb = STAGE_RESET;
    end else if (mem_wait) begin
      pc_en      = 1'b0;
      if_id.en   = 1'b0;
      id_ex.en   = 1'b0;
      ex_mem.en  = 1'b0;
      mem_wb.clr = 1'b1;
    end else if (md_stall) begin
      pc_en      = 1'b0;
      if_id.en   = 1'b0;
      id_ex.en   = 1'b0;
      ex_mem.clr = 1'b1;
    end else if (load_use) begin
      pc_en     = 1'b0;
      if_id.en  = 1'b0;
      id_ex.clr = 1'b1;
    end else if (id_branch_taken_i) begin
      if_id.clr = 1'b1;
    end
  end

  assign pc_en_o      = pc_en;
  assign if_id_en_o   = if_id.en;
  assign if_id_clr_o  = if_id.clr;
  assign id_ex_en_o   = id_ex.en;
  assign id_ex_clr_o  = id_ex.clr;
  assign ex_mem_en_o  = ex_mem.en;
  assign ex_mem_clr_o = ex_mem.clr;
  assign mem_wb_en_o  = mem_wb.en;
  assign mem_wb_clr_o = mem_wb.clr;

  assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + CntWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt  <= '0;
      mem_err_o <= 1'b0;
    end else if (mem_wait) begin
      wait_cnt <= wait_inc;
      if (32'(wait_inc) >= MemTimeout) begin
        mem_err_o <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed control vectors.
module tb_pipeline_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic       id_use_rs_i, id_use_rt_i, id_branch_taken_i;
  logic       ex_mem_read_i, ex_md_start_i, ex_md_is_div_i;
  logic       mem_req_i, mem_ready_i;
  logic       pc_en_o, if_id_en_o, if_id_clr_o, id_ex_en_o, id_ex_clr_o;
  logic       ex_mem_en_o, ex_mem_clr_o, mem_wb_en_o, mem_wb_clr_o;
  logic       md_done_o, mem_err_o;

  int checks = 0;
  int errors = 0;

  // {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr}
  localparam logic [8:0] C_DEF = 9'b110101010;
  localparam logic [8:0] C_LU  = 9'b000111010;
  localparam logic [8:0] C_MD  = 9'b000001110;
  localparam logic [8:0] C_MW  = 9'b000000011;
  localparam logic [8:0] C_BR  = 9'b111101010;
  localparam logic [8:0] C_RST = 9'b001010101;

  logic [8:0] ctl;
  assign ctl = {pc_en_o, if_id_en_o, if_id_clr_o, id_ex_en_o, id_ex_clr_o,
                ex_mem_en_o, ex_mem_clr_o, mem_wb_en_o, mem_wb_clr_o};

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(
    .MultCycles(4),
    .DivCycles (32),
    .MemTimeout(4),
    .CntWidth  (8)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .id_rs_i          (id_rs_i),
    .id_rt_i          (id_rt_i),
    .id_use_rs_i      (id_use_rs_i),
    .id_use_rt_i      (id_use_rt_i),
    .id_branch_taken_i(id_branch_taken_i),
    .ex_mem_read_i    (ex_mem_read_i),
    .ex_rt_i          (ex_rt_i),
    .ex_md_start_i    (ex_md_start_i),
    .ex_md_is_div_i   (ex_md_is_div_i),
    .mem_req_i        (mem_req_i),
    .mem_ready_i      (mem_ready_i),
    .pc_en_o          (pc_en_o),
    .if_id_en_o       (if_id_en_o),
    .if_id_clr_o      (if_id_clr_o),
    .id_ex_en_o       (id_ex_en_o),
    .id_ex_clr_o      (id_ex_clr_o),
    .ex_mem_en_o      (ex_mem_en_o),
    .ex_mem_clr_o     (ex_mem_clr_o),
    .mem_wb_en_o      (mem_wb_en_o),
    .mem_wb_clr_o     (mem_wb_clr_o),
    .md_done_o        (md_done_o),
    .mem_err_o        (mem_err_o)
  );

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are set here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle before sampling.
  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    id_rs_i = '0; id_rt_i = '0; ex_rt_i = '0;
    id_use_rs_i = 1'b0; id_use_rt_i = 1'b0; id_branch_taken_i = 1'b0;
    ex_mem_read_i = 1'b0; ex_md_start_i = 1'b0; ex_md_is_div_i = 1'b0;
    mem_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    chk("reset_ctl", ctl, C_RST);
    chk("reset_done", 9'(md_done_o), 9'd0);
    chk("reset_err", 9'(mem_err_o), 9'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    settle();
    chk("idle", ctl, C_DEF);

    // Load-use on rs, then the same with $zero destination
    tick();
    ex_mem_read_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8; id_use_rs_i = 1'b1;
    settle();
    chk("lu_rs", ctl, C_LU);
    tick();
    ex_rt_i = 5'd0; id_rs_i = 5'd0;
    settle();
    chk("lu_zero", ctl, C_DEF);
    tick();
    ex_rt_i = 5'd9; id_rs_i = 5'd3; id_rt_i = 5'd9; id_use_rs_i = 1'b0; id_use_rt_i = 1'b1;
    settle();
    chk("lu_rt", ctl, C_LU);
    tick();
    id_use_rt_i = 1'b0;
    settle();
    chk("lu_unused_rt", ctl, C_DEF);

    // Branch coinciding with load-use is suppressed, then applies alone
    tick();
    id_use_rt_i = 1'b1; id_branch_taken_i = 1'b1;
    settle();
    chk("br_lu", ctl, C_LU);
    tick();
    ex_mem_read_i = 1'b0;
    settle();
    chk("br_alone", ctl, C_BR);
    tick();
    idle_inputs();
    settle();
    chk("post_br", ctl, C_DEF);

    // Division: 32 stall cycles, then done pulse
    tick();
    ex_md_start_i = 1'b1; ex_md_is_div_i = 1'b1;
    settle();
    chk("div_c1", ctl, C_MD);
    for (int i = 2; i <= 32; i++) begin
      tick();
      ex_md_start_i = 1'b0;
      settle();
      chk("div_stall", ctl, C_MD);
      chk("div_done_low", 9'(md_done_o), 9'd0);
    end
    tick();
    settle();
    chk("div_c33", ctl, C_DEF);
    chk("div_done", 9'(md_done_o), 9'd1);
    tick();
    settle();
    chk("div_done_clr", 9'(md_done_o), 9'd0);

    // Division with a 3-cycle memory wait starting at MD cycle 5
    tick();
    ex_md_start_i = 1'b1; ex_md_is_div_i = 1'b1;
    settle();
    chk("divw_c1", ctl, C_MD);
    for (int i = 2; i <= 35; i++) begin
      tick();
      ex_md_start_i = 1'b0;
      mem_req_i = (i >= 5 && i <= 7);
      settle();
      if (i >= 5 && i <= 7) chk("divw_wait", ctl, C_MW);
      else chk("divw_stall", ctl, C_MD);
      chk("divw_done_low", 9'(md_done_o), 9'd0);
    end
    tick();
    settle();
    chk("divw_c36", ctl, C_DEF);
    chk("divw_done", 9'(md_done_o), 9'd1);
    chk("divw_no_err", 9'(mem_err_o), 9'd0);

    // Multiply: 4 stall cycles
    tick();
    ex_md_start_i = 1'b1; ex_md_is_div_i = 1'b0;
    settle();
    chk("mul_c1", ctl, C_MD);
    for (int i = 2; i <= 4; i++) begin
      tick();
      ex_md_start_i = 1'b0;
      settle();
      chk("mul_stall", ctl, C_MD);
    end
    tick();
    settle();
    chk("mul_c5", ctl, C_DEF);
    chk("mul_done", 9'(md_done_o), 9'd1);

    // Access completing immediately is not a wait
    tick();
    mem_req_i = 1'b1; mem_ready_i = 1'b1;
    settle();
    chk("mem_ready", ctl, C_DEF);

    // Timeout after 4 consecutive wait cycles, sticky afterwards
    for (int i = 1; i <= 6; i++) begin
      tick();
      mem_ready_i = 1'b0;
      settle();
      chk("to_wait", ctl, C_MW);
      chk("to_err", 9'(mem_err_o), (i >= 5) ? 9'd1 : 9'd0);
    end
    tick();
    mem_ready_i = 1'b1;
    settle();
    chk("to_recover", ctl, C_DEF);
    chk("to_sticky", 9'(mem_err_o), 9'd1);

    // Reset during a multiply aborts immediately
    tick();
    idle_inputs();
    ex_md_start_i = 1'b1;
    settle();
    chk("rmul_c1", ctl, C_MD);
    tick();
    ex_md_start_i = 1'b0;
    settle();
    chk("rmul_c2", ctl, C_MD);
    rst_ni = 1'b0;
    #1;
    chk("rmul_rst_ctl", ctl, C_RST);
    chk("rmul_rst_err", 9'(mem_err_o), 9'd0);
    chk("rmul_rst_done", 9'(md_done_o), 9'd0);
    tick();
    rst_ni = 1'b1;
    settle();
    chk("rmul_after", ctl, C_DEF);
    chk("rmul_after_done", 9'(md_done_o), 9'd0);
    tick();
    settle();
    chk("rmul_after2", ctl, C_DEF);
    chk("rmul_after2_done", 9'(md_done_o), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
